// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that gives several byte requesters shared, frame-atomic
// access to one UART transmitter. Frames are never interleaved. A grant is
// revoked if its owner stays idle for too long while it holds the lock.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | no owner; pick the next valid requester from ptr upward
// LOCKED     | owner holds the grant; ready follows owner valid; idle timer runs
// WAIT_DONE  | byte launched on the UART; waiting for i_tx_done
module uart_tx_arbiter #(
    parameter int NB_DATA        = 8,
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [N_REQ-1:0]           i_req_valid,
    input  logic [N_REQ*NB_DATA-1:0]   i_req_data,
    input  logic [N_REQ-1:0]           i_req_last,
    output logic [N_REQ-1:0]           o_req_ready,
    output logic [N_REQ-1:0]           o_grant,
    input  logic                       i_tx_done,
    output logic                       o_tx_start,
    output logic [NB_DATA-1:0]         o_tx_data,
    output logic                       o_busy,
    output logic                       o_timeout
);

    localparam int               IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [15:0]      TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [N_REQ-1:0] ONE_HOT = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOCKED    = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [N_REQ-1:0]     grant_q, grant_d;
    logic                 tx_start_q, tx_start_d;
    logic [NB_DATA-1:0]   tx_data_q, tx_data_d;
    logic                 timeout_q, timeout_d;
    logic                 last_q, last_d;
    logic [15:0]          cnt_q, cnt_d;

    logic [IDX_W:0]       arb_sum;
    logic [IDX_W-1:0]     arb_idx;
    logic                 owner_valid;
    logic                 owner_last;
    logic [NB_DATA-1:0]   owner_data;
    logic [IDX_W-1:0]     ptr_after;

    assign owner_valid = i_req_valid[owner_q];
    assign owner_last  = i_req_last[owner_q];
    assign owner_data  = i_req_data[int'(owner_q)*NB_DATA +: NB_DATA];
    assign ptr_after   = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

    // Round-robin search: first valid requester at or above ptr, wrapping.
    // Scanning offsets downward lets the smallest offset win.
    always_comb begin
        arb_idx = '0;
        arb_sum = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            arb_sum = {1'b0, ptr_q} + (IDX_W+1)'(j);
            if (arb_sum >= (IDX_W+1)'(N_REQ)) begin
                arb_sum = arb_sum - (IDX_W+1)'(N_REQ);
            end
            if (i_req_valid[arb_sum[IDX_W-1:0]]) begin
                arb_idx = arb_sum[IDX_W-1:0];
            end
        end
    end

    // State register: all flops, synchronous active-high reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            grant_q    <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            timeout_q  <= 1'b0;
            last_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            grant_q    <= grant_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            timeout_q  <= timeout_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state and datapath: arbitration, accept, done handling, idle timeout.
    // The idle counter defaults to zero so any state change clears it.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        grant_d    = grant_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        timeout_d  = 1'b0;
        last_d     = last_q;
        cnt_d      = '0;
        case (state_q)
            ST_IDLE: begin
                if (|i_req_valid) begin
                    owner_d = arb_idx;
                    grant_d = ONE_HOT << arb_idx;
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (owner_valid) begin
                    // An accept in the final timer cycle wins over the timeout.
                    tx_data_d  = owner_data;
                    last_d     = owner_last;
                    tx_start_d = 1'b1;
                    state_d    = ST_WAIT_DONE;
                end else if (cnt_q == TO_LAST) begin
                    grant_d   = '0;
                    timeout_d = 1'b1;
                    ptr_d     = ptr_after;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_WAIT_DONE: begin
                // A done coinciding with the start pulse belongs to an earlier byte.
                if (i_tx_done && !tx_start_q) begin
                    if (last_q) begin
                        grant_d = '0;
                        ptr_d   = ptr_after;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs: ready is combinational and forced low during reset.
    always_comb begin
        o_req_ready = '0;
        if (state_q == ST_LOCKED && !i_reset) begin
            o_req_ready = grant_q & i_req_valid;
        end
        o_busy     = (state_q != ST_IDLE);
        o_grant    = grant_q;
        o_tx_start = tx_start_q;
        o_tx_data  = tx_data_q;
        o_timeout  = timeout_q;
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (4 requesters, 8-cycle timeout).
// Requester byte sources are queues; every byte expected on the UART is pushed
// to a scoreboard when stimulus is queued and popped on each o_tx_start.
module tb_uart_tx_arbiter;

    localparam int NB = 8;
    localparam int NR = 4;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     valid;
    logic [NR*NB-1:0]  data;
    logic [NR-1:0]     last;
    logic [NR-1:0]     ready;
    logic [NR-1:0]     grant;
    logic              tx_done;
    logic              tx_start;
    logic [NB-1:0]     tx_data;
    logic              busy;
    logic              timeout;

    logic              auto_en   = 1'b1;
    logic              auto_done = 1'b0;
    logic              man_done  = 1'b0;
    int                cd        = 0;

    logic [8:0]        src_q [NR][$];
    logic [NR-1:0]     src_ne = '0;
    logic [8:0]        head [NR] = '{default: 9'h0};
    logic [NR-1:0]     acc = '0;

    logic [15:0]       sb [$];
    logic [15:0]       mon_e;
    int                viol  = 0;
    int                n_cmp = 0;
    int                n_bad = 0;

    always #5 clk = ~clk;

    assign tx_done = auto_done | man_done;

    uart_tx_arbiter #(
        .NB_DATA        (NB),
        .N_REQ          (NR),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_req_valid (valid),
        .i_req_data  (data),
        .i_req_last  (last),
        .o_req_ready (ready),
        .o_grant     (grant),
        .i_tx_done   (tx_done),
        .o_tx_start  (tx_start),
        .o_tx_data   (tx_data),
        .o_busy      (busy),
        .o_timeout   (timeout)
    );

    always_comb begin
        valid = '0;
        data  = '0;
        last  = '0;
        for (int k = 0; k < NR; k++) begin
            valid[k]           = src_ne[k];
            data[k*NB +: NB]   = head[k][7:0];
            last[k]            = head[k][8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Accepts are sampled mid-cycle; the head byte advances just after the edge.
    always @(negedge clk) acc = valid & ready;

    always @(posedge clk) begin
        #2;
        for (int k = 0; k < NR; k++) begin
            if (acc[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
            src_ne[k] = (src_q[k].size() > 0);
            head[k]   = src_ne[k] ? src_q[k][0] : 9'h0;
        end
    end

    // UART model: done pulse 10 cycles after each start when enabled.
    always @(posedge clk) begin
        #1;
        auto_done = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) auto_done = 1'b1;
        end
        if (tx_start && auto_en) cd = 10;
    end

    // Scoreboard check on every launched byte; ready must stay inside grant.
    always @(negedge clk) begin
        if (tx_start) begin
            chk("start_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("tx_data", 32'(tx_data), 32'(mon_e[7:0]));
                chk("tx_grant", 32'(grant), 32'(4'b0001 << mon_e[9:8]));
            end
        end
        if ((ready & ~grant) != '0) viol++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int k, input logic [7:0] d, input logic l);
        src_q[k].push_back({l, d});
        sb.push_back({6'd0, 2'(k), d});
    endtask

    function automatic bit srcs_empty();
        bit e = 1'b1;
        for (int k = 0; k < NR; k++) if (src_q[k].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic wait_start(input string tag);
        int n = 0;
        tick(1);
        while (!tx_start && n < 200) begin
            tick(1);
            n++;
        end
        chk({tag, "_start_seen"}, 32'(tx_start), 32'd1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        tick(1);
        while (!(sb.size() == 0 && !busy && srcs_empty()) && n < 300) begin
            tick(1);
            n++;
        end
        chk({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        // Reset values
        tick(3);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        rst = 1'b0;
        tick(1);

        // Single 3-byte frame from req0, then ptr=1 makes req1 win over req0
        push(0, 8'h11, 1'b0);
        push(0, 8'h22, 1'b0);
        push(0, 8'h33, 1'b1);
        drain("frame3");
        chk("frame3_grant_clear", 32'(grant), 32'd0);
        push(1, 8'h41, 1'b1);
        push(0, 8'h40, 1'b1);
        drain("ptr1");

        // Round-robin 0,1,2,3,0 after reset
        do_reset();
        push(0, 8'hA0, 1'b1);
        push(1, 8'hA1, 1'b1);
        push(2, 8'hA2, 1'b1);
        push(3, 8'hA3, 1'b1);
        push(0, 8'hA4, 1'b1);
        drain("rr");
        // ptr becomes 2 after req1; then req3 beats req1
        push(1, 8'hB0, 1'b1);
        drain("rr_b0");
        push(3, 8'hB1, 1'b1);
        push(1, 8'hB2, 1'b1);
        drain("rr_ptr2");

        // No interleave: req2 waits out req0's 4-byte frame
        do_reset();
        push(0, 8'hC0, 1'b0);
        push(0, 8'hC1, 1'b0);
        push(0, 8'hC2, 1'b0);
        push(0, 8'hC3, 1'b1);
        push(2, 8'hC4, 1'b1);
        for (int b = 0; b < 4; b++) wait_start("nointlv");
        tick(11);
        chk("nointlv_bubble_grant", 32'(grant), 32'd0);
        chk("nointlv_bubble_ready", 32'(ready), 32'd0);
        tick(1);
        chk("nointlv_grant2", 32'(grant), 32'b0100);
        chk("nointlv_ready2", 32'(ready), 32'b0100);
        drain("nointlv");

        // Timeout: req1 sends one non-last byte then goes quiet
        do_reset();
        auto_en = 1'b0;
        push(1, 8'h5A, 1'b0);
        wait_start("to");
        tick(3);
        man_done = 1'b1;
        tick(1);
        man_done = 1'b0;
        tick(7);
        chk("to_before_pulse", 32'(timeout), 32'd0);
        chk("to_before_grant", 32'(grant), 32'b0010);
        tick(1);
        chk("to_pulse", 32'(timeout), 32'd1);
        chk("to_grant_clear", 32'(grant), 32'd0);
        chk("to_busy", 32'(busy), 32'd0);
        tick(1);
        chk("to_pulse_width", 32'(timeout), 32'd0);
        auto_en = 1'b1;
        push(2, 8'h62, 1'b1);
        push(0, 8'h60, 1'b1);
        push(1, 8'h61, 1'b1);
        drain("to_ptr2");

        // Accept in the final timer cycle beats the timeout
        do_reset();
        auto_en = 1'b0;
        push(1, 8'h70, 1'b0);
        wait_start("prec");
        tick(3);
        man_done = 1'b1;
        tick(1);
        man_done = 1'b0;
        tick(7);
        push(1, 8'h77, 1'b1);
        tick(1);
        chk("prec_no_timeout", 32'(timeout), 32'd0);
        chk("prec_start", 32'(tx_start), 32'd1);
        chk("prec_data", 32'(tx_data), 32'h77);
        tick(2);
        man_done = 1'b1;
        tick(1);
        man_done = 1'b0;
        drain("prec");

        // Done coinciding with the start pulse is ignored
        do_reset();
        push(1, 8'hA1, 1'b0);
        push(1, 8'hA2, 1'b1);
        wait_start("stale");
        man_done = 1'b1;
        tick(1);
        man_done = 1'b0;
        chk("stale_ready_held", 32'(ready), 32'd0);
        chk("stale_busy", 32'(busy), 32'd1);
        tick(3);
        chk("stale_data_stable", 32'(tx_data), 32'hA1);
        chk("stale_ready_still", 32'(ready), 32'd0);
        man_done = 1'b1;
        tick(1);
        man_done = 1'b0;
        chk("stale_relocked_ready", 32'(ready), 32'b0010);
        wait_start("stale2");
        tick(2);
        man_done = 1'b1;
        tick(1);
        man_done = 1'b0;
        drain("stale");

        // Reset during WAIT_DONE, then a stale done
        push(0, 8'hC3, 1'b1);
        wait_start("rstmid");
        tick(2);
        rst = 1'b1;
        tick(1);
        chk("rstmid_grant", 32'(grant), 32'd0);
        chk("rstmid_tx_start", 32'(tx_start), 32'd0);
        chk("rstmid_tx_data", 32'(tx_data), 32'd0);
        chk("rstmid_timeout", 32'(timeout), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_ready", 32'(ready), 32'd0);
        rst = 1'b0;
        man_done = 1'b1;
        tick(1);
        man_done = 1'b0;
        chk("rstmid_done_no_start", 32'(tx_start), 32'd0);
        chk("rstmid_done_idle", 32'(busy), 32'd0);
        tick(2);
        chk("rstmid_still_idle", 32'(busy), 32'd0);
        chk("rstmid_grant_zero", 32'(grant), 32'd0);

        // Ready stays low during reset and in the first cycle after it
        rst = 1'b1;
        push(2, 8'hD4, 1'b1);
        tick(1);
        chk("rstrdy_during", 32'(ready), 32'd0);
        rst = 1'b0;
        chk("rstrdy_first_after", 32'(ready), 32'd0);
        tick(1);
        chk("rstrdy_grant", 32'(grant), 32'b0100);
        chk("rstrdy_ready", 32'(ready), 32'b0100);
        auto_en = 1'b1;
        drain("rstrdy");

        chk("ready_within_grant", 32'(viol), 32'd0);
        chk("sb_final_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NB_DATA, default 8, UART byte width.
REQ-002 Parameter N_REQ, default 4, number of requesters; legal range 2..8.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024, owner-idle cycles before a grant is revoked; legal range 2..65535.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 i_clk  in  1  clock; all state changes on its rising edge.
REQ-006 i_reset  in  1  synchronous active-high reset.
REQ-007 i_req_valid  in  N_REQ  bit k: requester k presents a byte.
REQ-008 i_req_data  in  N_REQ*NB_DATA  requester k byte at bits [k*NB_DATA +: NB_DATA].
REQ-009 i_req_last  in  N_REQ  bit k: presented byte is the final byte of requester k's frame.
REQ-010 o_req_ready  out  N_REQ  one-hot accept; byte k is consumed in a cycle where valid[k] and ready[k] are both 1.
REQ-011 o_grant  out  N_REQ  one-hot current frame owner; all-zero when unowned.
REQ-012 i_tx_done  in  1  UART transmitter finished the current byte (1-cycle pulse).
REQ-013 o_tx_start  out  1  1-cycle pulse that launches o_tx_data on the UART transmitter.
REQ-014 o_tx_data  out  NB_DATA  byte to transmit; stable from o_tx_start until the matching i_tx_done.
REQ-015 o_busy  out  1  high whenever state is not IDLE.
REQ-016 o_timeout  out  1  1-cycle pulse when a grant is revoked by timeout.

Function
REQ-017 The FSM SHALL have the states IDLE, LOCKED and WAIT_DONE; o_tx_start, o_timeout, o_grant and o_tx_data SHALL be registered, and o_req_ready SHALL be combinational from state, owner and i_req_valid.
REQ-018 IDLE: if any i_req_valid bit is set, the block SHALL select the first set bit searching upward from pointer ptr, modulo N_REQ; it SHALL register the selection in o_grant and enter LOCKED on the next edge. With no valid bits set, it SHALL stay in IDLE.
REQ-019 Arbitration SHALL take exactly one cycle. A requester SHALL NOT receive ready in the cycle it is granted.
REQ-020 LOCKED: o_req_ready[owner] SHALL equal i_req_valid[owner]; all other ready bits SHALL be 0.
REQ-021 On an accept, the block SHALL latch the data into o_tx_data and latch the last flag, and SHALL drive o_tx_start=1 for exactly the next cycle while entering WAIT_DONE.
REQ-022 While LOCKED, i_req_valid bits of non-owners SHALL be ignored; a frame is never interleaved with another requester's bytes.
REQ-023 WAIT_DONE: i_tx_done SHALL be ignored in the cycle o_tx_start=1. On a later i_tx_done:
  - if the latched last flag is 0, the block SHALL return to LOCKED;
  - if it is 1, the block SHALL clear o_grant, set ptr=(owner+1) mod N_REQ, and enter IDLE.
REQ-024 Timeout: in LOCKED, a 16-bit counter SHALL increment on each cycle with i_req_valid[owner]=0 and SHALL clear on accept or on any state change.
  - When the counter reaches TIMEOUT_CYCLES-1 with owner valid still 0, the block SHALL clear o_grant, pulse o_timeout for 1 cycle, set ptr=(owner+1) mod N_REQ, and enter IDLE.
  - If owner valid is 1 in that same cycle, the accept SHALL take precedence and no timeout SHALL occur.
REQ-025 Timeout SHALL NOT apply in WAIT_DONE; the block waits indefinitely for i_tx_done.
REQ-026 Minimum byte-to-byte spacing: there is one accept per i_tx_done, plus 1 cycle LOCKED->accept. A frame release is followed by a 1-cycle IDLE arbitration bubble.
REQ-027 A requester that drops valid mid-frame keeps its grant until the frame's last byte or until timeout.

Reset
REQ-028 When i_reset=1 at a clock edge, the block SHALL set state=IDLE, ptr=0, o_grant=0, o_tx_start=0, o_tx_data=0, o_timeout=0, o_busy=0, counter=0, and the latched last flag=0.
REQ-029 Reset during WAIT_DONE SHALL abandon the frame. A stale i_tx_done arriving after reset SHALL be ignored because the block is in IDLE; the byte already on the UART is not aborted.
REQ-030 o_req_ready SHALL be all-zero while i_reset=1 and in the first cycle after reset.

Verification
REQ-031 Single frame: req0 sends 3 bytes 0x11,0x22,0x33 with last on 0x33, and tx_done is returned 10 cycles after each start -> 3 tx_start pulses carrying 0x11,0x22,0x33 in order; grant=0001 throughout; return to IDLE; ptr=1.
REQ-032 Round-robin: req0..req3 all valid with 1-byte frames after reset -> grants in order 0,1,2,3,0. With req1 and req3 valid and ptr=2 -> req3 is granted first.
REQ-033 No interleave: req2 is valid during req0's 4-byte frame -> req2 receives no ready until req0's last-byte tx_done, then is granted 1 cycle later.
REQ-034 Timeout with TIMEOUT_CYCLES=8: req1 sends 1 non-last byte and then drops valid -> o_timeout pulses 8 cycles after re-entering LOCKED; grant=0000; ptr=2. A valid arriving in the 8th cycle is accepted with no timeout.
REQ-035 Reset mid-frame: assert i_reset during WAIT_DONE, then pulse i_tx_done -> all outputs at reset values; no tx_start; IDLE.
REQ-036 Stale done: i_tx_done asserted in the same cycle as o_tx_start -> remains in WAIT_DONE until the next i_tx_done.
